// File: rtl/spi_write_controller_if.sv
// Write-side bus between spi_write_controller and the shared register buffer.
// Optional macro: WR_ERR_FLAG_EN adds the sticky oWr_ERR flag.
//
// Handshake: oWr_EN is a one-cycle valid qualifying oWr_ADDR/oWr_DATA. There is
// no ready; the buffer must accept every strobe. oWr_ADDR/oWr_DATA hold their
// last values while oWr_EN is low. oWr_DONE is a one-cycle pulse in the cycle
// after the write to the last address.
// dbg_state exposes the FSM: 0=CMD, 1=DATA, 2=DONE, 3=IGNORE.
interface spi_write_controller_if #(
    parameter int DW = 8,
    parameter int AW = 5
);
    logic          oWr_EN;
    logic [AW-1:0] oWr_ADDR;
    logic [DW-1:0] oWr_DATA;
    logic          oWr_DONE;
`ifdef WR_ERR_FLAG_EN
    logic          oWr_ERR;
`endif
    logic [1:0]    dbg_state;

    modport master (
        output oWr_EN,
        output oWr_ADDR,
        output oWr_DATA,
        output oWr_DONE,
`ifdef WR_ERR_FLAG_EN
        output oWr_ERR,
`endif
        output dbg_state
    );

    modport slave (
        input oWr_EN,
        input oWr_ADDR,
        input oWr_DATA,
        input oWr_DONE,
`ifdef WR_ERR_FLAG_EN
        input oWr_ERR,
`endif
        input dbg_state
    );
endinterface

// File: rtl/spi_write_controller.sv
// SPI-slave write path: shifts MOSI in MSB first on each iEN strobe, decodes the
// first byte of a frame as {write flag, start address}, then writes every
// following byte to incrementing buffer addresses up to LAST_ADDR.
// Optional macro: WR_ERR_FLAG_EN adds a sticky error flag for invalid commands
// and for bytes arriving after the burst has reached LAST_ADDR.
module spi_write_controller #(
    parameter int            DW        = 8,
    parameter int            AW        = 5,
    parameter logic [AW-1:0] LAST_ADDR = 5'd19
) (
    input  logic iCLK,
    input  logic iRSTn,
    input  logic iCLR,
    input  logic iEN,
    input  logic MOSI,
    spi_write_controller_if.master wr_if
);
    typedef enum logic [1:0] {
        CMD_ST    = 2'd0,
        DATA_ST   = 2'd1,
        DONE_ST   = 2'd2,
        IGNORE_ST = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    // Only the seven most recent bits are needed: the eighth arrives on MOSI
    // in the same cycle the byte completes.
    logic [DW-2:0] shift_q, shift_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          done_q, done_d;
`ifdef WR_ERR_FLAG_EN
    logic          err_q, err_d;
    logic          from_done_q, from_done_d;
`endif

    logic [DW-1:0] rx_byte;
    logic          byte_done;
    logic [AW-1:0] cmd_addr;

    assign rx_byte   = {shift_q, MOSI};
    assign byte_done = iEN && (bit_cnt_q == 3'd7);
    assign cmd_addr  = rx_byte[AW-1:0];

    // Next-state and next-output computation; iCLR overrides everything.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
`ifdef WR_ERR_FLAG_EN
        err_d       = err_q;
        from_done_d = from_done_q;
`endif
        if (iCLR) begin
            state_d   = CMD_ST;
            bit_cnt_d = 3'd0;
            shift_d   = '0;
`ifdef WR_ERR_FLAG_EN
            err_d       = 1'b0;
            from_done_d = 1'b0;
`endif
        end else begin
            if (iEN) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                shift_d   = rx_byte[DW-2:0];
            end
            case (state_q)
                CMD_ST: begin
                    if (byte_done) begin
                        if (rx_byte[DW-1] && (cmd_addr <= LAST_ADDR)) begin
                            addr_d  = cmd_addr;
                            state_d = DATA_ST;
                        end else begin
                            state_d = IGNORE_ST;
`ifdef WR_ERR_FLAG_EN
                            err_d = 1'b1;
`endif
                        end
                    end
                end
                DATA_ST: begin
                    if (byte_done) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = rx_byte;
                        if (addr_q == LAST_ADDR) begin
                            state_d = DONE_ST;
                        end else begin
                            addr_d = addr_q + AW'(1);
                        end
                    end
                end
                DONE_ST: begin
                    done_d  = 1'b1;
                    state_d = IGNORE_ST;
`ifdef WR_ERR_FLAG_EN
                    from_done_d = 1'b1;
`endif
                end
                default: begin
`ifdef WR_ERR_FLAG_EN
                    if (byte_done && from_done_q) err_d = 1'b1;
`endif
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q   <= CMD_ST;
            bit_cnt_q <= 3'd0;
            shift_q   <= '0;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
`ifdef WR_ERR_FLAG_EN
            err_q       <= 1'b0;
            from_done_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
`ifdef WR_ERR_FLAG_EN
            err_q       <= err_d;
            from_done_q <= from_done_d;
`endif
        end
    end

    assign wr_if.oWr_EN    = wr_en_q;
    assign wr_if.oWr_ADDR  = wr_addr_q;
    assign wr_if.oWr_DATA  = wr_data_q;
    assign wr_if.oWr_DONE  = done_q;
    assign wr_if.dbg_state = state_q;
`ifdef WR_ERR_FLAG_EN
    assign wr_if.oWr_ERR   = err_q;
`endif
endmodule

// File: tb/tb_spi_write_controller.sv
// Bench for spi_write_controller: table of frames with hand-derived results,
// corner-case sequences, and random frames checked cycle by cycle against a
// frame-level reference model (byte index within frame -> buffer address).
module tb_spi_write_controller;
    localparam int    LAST = 19;
    localparam logic [1:0] ST_CMD    = 2'd0;
    localparam logic [1:0] ST_IGNORE = 2'd3;

    logic iCLK = 1'b0;
    logic iRSTn = 1'b0;
    logic iCLR = 1'b0;
    logic iEN = 1'b0;
    logic MOSI = 1'b0;

    always #5 iCLK = ~iCLK;

    spi_write_controller_if #(.DW(8), .AW(5)) wr_if ();

    spi_write_controller dut (
        .iCLK  (iCLK),
        .iRSTn (iRSTn),
        .iCLR  (iCLR),
        .iEN   (iEN),
        .MOSI  (MOSI),
        .wr_if (wr_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard of observed writes {addr, data} and DONE pulses.
    logic [12:0] obs_q[$];
    int          done_cnt;

    // Reference model: a frame is a stream of bytes; byte 0 is the command,
    // byte k>=1 goes to base+k-1 while that address is <= LAST.
    int         m_nbits, m_nbytes, m_base;
    logic [7:0] m_cur;
    logic       m_done_pend;
    logic       m_en, m_done, m_err;
    logic [4:0] m_addr;
    logic [7:0] m_data;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_frame_reset();
        m_nbits = 0; m_nbytes = 0; m_base = -1; m_cur = 8'h00;
        m_done_pend = 1'b0; m_en = 1'b0; m_done = 1'b0; m_err = 1'b0;
    endfunction

    function automatic void model_hw_reset();
        model_frame_reset();
        m_addr = 5'd0; m_data = 8'h00;
    endfunction

    function automatic void model_step(input logic clr, input logic en, input logic mosi);
        int a;
        if (clr) begin
            model_frame_reset();
            return;
        end
        m_done = m_done_pend;
        m_done_pend = 1'b0;
        m_en = 1'b0;
        if (en) begin
            m_cur = {m_cur[6:0], mosi};
            m_nbits++;
            if (m_nbits % 8 == 0) begin
                if (m_nbytes == 0) begin
                    if (m_cur[7] && (int'(m_cur[4:0]) <= LAST)) m_base = int'(m_cur[4:0]);
                    else m_err = 1'b1;
                end else if (m_base >= 0) begin
                    a = m_base + m_nbytes - 1;
                    if (a <= LAST) begin
                        m_en = 1'b1; m_addr = a[4:0]; m_data = m_cur;
                        if (a == LAST) m_done_pend = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                m_nbytes++;
            end
        end
    endfunction

    function automatic logic [15:0] dut_outs();
        logic e;
        e = 1'b0;
`ifdef WR_ERR_FLAG_EN
        e = wr_if.oWr_ERR;
`endif
        return {wr_if.oWr_EN, wr_if.oWr_DONE, wr_if.oWr_ADDR, wr_if.oWr_DATA, e};
    endfunction

    function automatic logic [15:0] model_outs();
        logic e;
        e = 1'b0;
`ifdef WR_ERR_FLAG_EN
        e = m_err;
`endif
        return {m_en, m_done, m_addr, m_data, e};
    endfunction

    // One clock: drive inputs, let the edge pass, compare every output.
    task automatic tick(input logic clr, input logic en, input logic mosi);
        iCLR = clr; iEN = en; MOSI = mosi;
        @(posedge iCLK);
        #1;
        model_step(clr, en, mosi);
        chk("cycle", 32'(dut_outs()), 32'(model_outs()));
        if (wr_if.oWr_EN) obs_q.push_back({wr_if.oWr_ADDR, wr_if.oWr_DATA});
        if (wr_if.oWr_DONE) done_cnt++;
        iCLR = 1'b0; iEN = 1'b0; MOSI = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits, input int max_gap);
        for (int i = 0; i < nbits; i++) begin
            tick(1'b0, 1'b1, b[7-i]);
            repeat ($urandom_range(0, max_gap)) tick(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic start_frame();
        tick(1'b1, 1'b0, 1'b0);
        obs_q.delete();
        done_cnt = 0;
    endtask

    task automatic apply_reset();
        iRSTn = 1'b0;
        #2;
        model_hw_reset();
        chk("reset_outs", 32'(dut_outs()), 32'h0);
        chk("reset_state", 32'(wr_if.dbg_state), 32'(ST_CMD));
        @(posedge iCLK);
        #1;
        iRSTn = 1'b1;
    endtask

    typedef struct {
        logic [7:0]  b[4];
        int          nb;
        int          gap;
        int          exp_wr;
        logic [12:0] exp_first;
        int          exp_done;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        model_hw_reset();
        done_cnt = 0;
        repeat (2) @(posedge iCLK);
        #1;
        apply_reset();

        vecs[0] = '{'{8'h80, 8'hA5, 8'h00, 8'h00}, 2, 1, 1, {5'd0,  8'hA5}, 0, 1'b0};
        vecs[1] = '{'{8'h92, 8'h11, 8'h22, 8'h33}, 4, 1, 2, {5'd18, 8'h11}, 1, 1'b1};
        vecs[2] = '{'{8'h05, 8'hFF, 8'h00, 8'h00}, 2, 1, 0, 13'h0,          0, 1'b1};
        vecs[3] = '{'{8'h94, 8'h12, 8'h00, 8'h00}, 2, 1, 0, 13'h0,          0, 1'b1};
        vecs[4] = '{'{8'h93, 8'hAB, 8'hCD, 8'h00}, 3, 2, 1, {5'd19, 8'hAB}, 1, 1'b1};
        vecs[5] = '{'{8'hA0, 8'h77, 8'h00, 8'h00}, 2, 1, 1, {5'd0,  8'h77}, 0, 1'b0};
        vecs[6] = '{'{8'h7F, 8'h01, 8'h00, 8'h00}, 2, 0, 0, 13'h0,          0, 1'b1};
        vecs[7] = '{'{8'h81, 8'hC3, 8'h00, 8'h00}, 2, 0, 1, {5'd1,  8'hC3}, 0, 1'b0};

        for (int v = 0; v < 8; v++) begin
            start_frame();
            for (int k = 0; k < vecs[v].nb; k++) send_bits(vecs[v].b[k], 8, vecs[v].gap);
            repeat (3) tick(1'b0, 1'b0, 1'b0);
            chk($sformatf("vec%0d_nwr", v), 32'(obs_q.size()), 32'(vecs[v].exp_wr));
            if (obs_q.size() > 0) chk($sformatf("vec%0d_first", v), 32'(obs_q[0]), 32'(vecs[v].exp_first));
            chk($sformatf("vec%0d_done", v), 32'(done_cnt), 32'(vecs[v].exp_done));
`ifdef WR_ERR_FLAG_EN
            chk($sformatf("vec%0d_err", v), 32'(wr_if.oWr_ERR), 32'(vecs[v].exp_err));
`endif
            if (v == 1 && obs_q.size() > 1) chk("vec1_second", 32'(obs_q[1]), 32'({5'd19, 8'h22}));
            if (v == 3) chk("bad_addr_ignore", 32'(wr_if.dbg_state), 32'(ST_IGNORE));
        end

        // Reset in the middle of a frame, then a frame without iCLR.
        start_frame();
        send_bits(8'hFF, 3, 0);
        apply_reset();
        obs_q.delete();
        send_bits(8'h80, 8, 1);
        send_bits(8'hA5, 8, 1);
        repeat (2) tick(1'b0, 1'b0, 1'b0);
        chk("rst_frame_nwr", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() > 0) chk("rst_frame_wr", 32'(obs_q[0]), 32'({5'd0, 8'hA5}));

        // Invalid address lands in IGNORE; iCLR returns to CMD and a new frame writes.
        start_frame();
        send_bits(8'h94, 8, 0);
        tick(1'b0, 1'b0, 1'b0);
        chk("ignore_state", 32'(wr_if.dbg_state), 32'(ST_IGNORE));
        start_frame();
        chk("clr_state", 32'(wr_if.dbg_state), 32'(ST_CMD));
        send_bits(8'h80, 8, 0);
        send_bits(8'h3C, 8, 0);
        tick(1'b0, 1'b0, 1'b0);
        chk("after_clr_nwr", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() > 0) chk("after_clr_wr", 32'(obs_q[0]), 32'({5'd0, 8'h3C}));

        // iCLR coincides with the 8th bit of a data byte: no write, fresh frame next.
        start_frame();
        send_bits(8'h80, 8, 0);
        send_bits(8'h5A, 7, 0);
        tick(1'b1, 1'b1, 1'b0);
        obs_q.delete();
        send_bits(8'h81, 8, 0);
        send_bits(8'h55, 8, 0);
        tick(1'b0, 1'b0, 1'b0);
        chk("clr_collide_nwr", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() > 0) chk("clr_collide_wr", 32'(obs_q[0]), 32'({5'd1, 8'h55}));

        // Random frames, random strobe spacing, occasional partial bytes and early clears.
        for (int f = 0; f < 40; f++) begin
            logic [7:0] cmd;
            int nb;
            start_frame();
            if ($urandom_range(0, 9) < 7) cmd = {1'b1, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 21))};
            else cmd = 8'($urandom);
            send_bits(cmd, 8, $urandom_range(0, 2));
            nb = $urandom_range(0, 6);
            for (int k = 0; k < nb; k++) send_bits(8'($urandom), 8, $urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) send_bits(8'($urandom), $urandom_range(1, 7), 1);
            if ($urandom_range(0, 4) == 0) tick(1'b1, 1'b1, 1'($urandom));
            repeat (2) tick(1'b0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
